// File: rtl/sirv_nch_sram_ctrl_cache_pkg.sv
// Shared definitions for the multi-channel cache-backed SRAM controller front end.
// Tag FIFO entries are laid out as {cid[CID_W-1:0], usr[USR_W-1:0]}.
package sirv_nch_sram_ctrl_cache_pkg;

    localparam int DEF_CH_NUM    = 2;
    localparam int DEF_OST_DEPTH = 4;

    // ARB_HOLD: a command was offered but not taken, so the grant is frozen
    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int calc_cid_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int calc_tag_w(input int ch_num, input int usr_w);
        return calc_cid_w(ch_num) + usr_w;
    endfunction

endpackage

// File: rtl/sirv_nch_tag_fifo.sv
// Synchronous tag FIFO holding {cid, usr} for each outstanding cache request.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sirv_nch_tag_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        head_o   = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/sirv_nch_sram_ctrl_cache.sv
// Multi-channel front end: round-robin arbitration of uop requesters onto one cache port,
// with in-order response routing driven by a tag FIFO of outstanding requests.
module sirv_nch_sram_ctrl_cache
    import sirv_nch_sram_ctrl_cache_pkg::*;
#(
    parameter int CH_NUM    = DEF_CH_NUM,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int AW_LSB    = 2,
    parameter int USR_W     = 3,
    parameter int OST_DEPTH = DEF_OST_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tcm_cgstop,
    input  logic [CH_NUM-1:0]       ch_cmd_valid,
    output logic [CH_NUM-1:0]       ch_cmd_ready,
    input  logic [CH_NUM-1:0]       ch_cmd_read,
    input  logic [CH_NUM*AW-1:0]    ch_cmd_addr,
    input  logic [CH_NUM*DW-1:0]    ch_cmd_wdata,
    input  logic [CH_NUM*DW/8-1:0]  ch_cmd_wmask,
    input  logic [CH_NUM*USR_W-1:0] ch_cmd_usr,
    output logic [CH_NUM-1:0]       ch_rsp_valid,
    input  logic [CH_NUM-1:0]       ch_rsp_ready,
    output logic [DW-1:0]           ch_rsp_rdata,
    output logic [USR_W-1:0]        ch_rsp_usr,
    output logic                    c_cmd_valid,
    input  logic                    c_cmd_ready,
    output logic                    c_cmd_read,
    output logic [AW-AW_LSB-1:0]    c_cmd_addr,
    output logic [DW-1:0]           c_cmd_wdata,
    output logic [DW/8-1:0]         c_cmd_wmask,
    input  logic                    c_rsp_valid,
    output logic                    c_rsp_ready,
    input  logic [DW-1:0]           c_rsp_rdata,
    output logic                    sram_ctrl_active,
    output logic                    proto_err,
    output arb_state_e              dbg_arb_state
);

    localparam int MW    = DW / 8;
    localparam int CAW   = AW - AW_LSB;
    localparam int CID_W = calc_cid_w(CH_NUM);
    localparam int TAG_W = calc_tag_w(CH_NUM, USR_W);

    // Handshake rule on every port here: a transfer happens in a cycle where valid and
    // ready are both high; a source holds valid and its payload stable until that cycle.

    arb_state_e        arb_state_q, arb_state_d;
    logic [CID_W-1:0]  hold_gnt_q, hold_gnt_d;
    logic [CID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CID_W-1:0]  scan_gnt;
    logic [CID_W-1:0]  gnt;
    logic              scan_found;
    int                scan_idx;
    logic              accept;
    logic              stall;
    logic [USR_W-1:0]  gnt_usr;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [TAG_W-1:0]  push_tag;
    logic [TAG_W-1:0]  head_tag;
    logic [CID_W-1:0]  head_cid;
    logic              proto_err_q;

    // Round-robin scan: first valid channel at or after rr_ptr
    always_comb begin
        scan_gnt   = rr_ptr_q;
        scan_found = 1'b0;
        scan_idx   = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % CH_NUM;
            if (!scan_found && ch_cmd_valid[scan_idx]) begin
                scan_gnt   = CID_W'(scan_idx);
                scan_found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = scan_gnt;
        if (arb_state_q == ARB_HOLD && ch_cmd_valid[hold_gnt_q]) begin
            gnt = hold_gnt_q;
        end
    end

    always_comb begin
        c_cmd_valid = (|ch_cmd_valid) & ~fifo_full;
        accept      = c_cmd_valid & c_cmd_ready;
        stall       = c_cmd_valid & ~c_cmd_ready;
        c_cmd_read  = 1'b0;
        c_cmd_addr  = '0;
        c_cmd_wdata = '0;
        c_cmd_wmask = '0;
        gnt_usr     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_cmd_ready[i] = (gnt == CID_W'(i)) & c_cmd_ready & ~fifo_full;
            if (gnt == CID_W'(i)) begin
                c_cmd_read  = ch_cmd_read[i];
                c_cmd_addr  = ch_cmd_addr[i*AW+AW_LSB +: CAW];
                c_cmd_wdata = ch_cmd_wdata[i*DW +: DW];
                c_cmd_wmask = ch_cmd_wmask[i*MW +: MW];
                gnt_usr     = ch_cmd_usr[i*USR_W +: USR_W];
            end
        end
        push_tag = {gnt, gnt_usr};
    end

    always_comb begin
        arb_state_d = stall ? ARB_HOLD : ARB_FREE;
        hold_gnt_d  = stall ? gnt : hold_gnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(gnt) == CH_NUM - 1) ? '0 : gnt + CID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_state_q <= ARB_FREE;
            hold_gnt_q  <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            arb_state_q <= arb_state_d;
            hold_gnt_q  <= hold_gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_q | (c_rsp_valid & fifo_empty);
        end
    end

    // A full FIFO refuses the push even when a pop lands in the same cycle,
    // keeping c_rsp_valid out of the ch_cmd_ready path.
    sirv_nch_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (OST_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept),
        .push_data_i (push_tag),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_tag)
    );

    always_comb begin
        head_cid    = head_tag[TAG_W-1 -: CID_W];
        ch_rsp_usr  = head_tag[USR_W-1:0];
        c_rsp_ready = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_rsp_valid[i] = c_rsp_valid & ~fifo_empty & (head_cid == CID_W'(i));
            if (head_cid == CID_W'(i)) begin
                c_rsp_ready = ch_rsp_ready[i] & ~fifo_empty;
            end
        end
        pop = c_rsp_valid & c_rsp_ready;
    end

    assign ch_rsp_rdata     = c_rsp_rdata;
    assign proto_err        = proto_err_q;
    assign dbg_arb_state    = arb_state_q;
    assign sram_ctrl_active = tcm_cgstop | (|ch_cmd_valid) | ~fifo_empty | c_rsp_valid;

endmodule

// File: tb/tb_sirv_nch_sram_ctrl_cache.sv
// Directed and randomized checks of the multi-channel SRAM controller front end against
// a queue-based model of outstanding requests.
module tb_sirv_nch_sram_ctrl_cache;
    import sirv_nch_sram_ctrl_cache_pkg::*;

    localparam int CH     = 2;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int AW_LSB = 2;
    localparam int USR_W  = 3;
    localparam int OST    = 4;
    localparam int MW     = DW / 8;
    localparam int CID_W  = 1;
    localparam int TAG_W  = CID_W + USR_W;

    logic                   clk;
    logic                   rst_n;
    logic                   tcm_cgstop;
    logic [CH-1:0]          ch_cmd_valid;
    logic [CH-1:0]          ch_cmd_ready;
    logic [CH-1:0]          ch_cmd_read;
    logic [CH*AW-1:0]       ch_cmd_addr;
    logic [CH*DW-1:0]       ch_cmd_wdata;
    logic [CH*MW-1:0]       ch_cmd_wmask;
    logic [CH*USR_W-1:0]    ch_cmd_usr;
    logic [CH-1:0]          ch_rsp_valid;
    logic [CH-1:0]          ch_rsp_ready;
    logic [DW-1:0]          ch_rsp_rdata;
    logic [USR_W-1:0]       ch_rsp_usr;
    logic                   c_cmd_valid;
    logic                   c_cmd_ready;
    logic                   c_cmd_read;
    logic [AW-AW_LSB-1:0]   c_cmd_addr;
    logic [DW-1:0]          c_cmd_wdata;
    logic [MW-1:0]          c_cmd_wmask;
    logic                   c_rsp_valid;
    logic                   c_rsp_ready;
    logic [DW-1:0]          c_rsp_rdata;
    logic                   sram_ctrl_active;
    logic                   proto_err;
    arb_state_e             dbg_arb_state;

    sirv_nch_sram_ctrl_cache #(
        .CH_NUM(CH), .DW(DW), .AW(AW), .AW_LSB(AW_LSB), .USR_W(USR_W), .OST_DEPTH(OST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tcm_cgstop(tcm_cgstop),
        .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready), .ch_cmd_read(ch_cmd_read),
        .ch_cmd_addr(ch_cmd_addr), .ch_cmd_wdata(ch_cmd_wdata), .ch_cmd_wmask(ch_cmd_wmask),
        .ch_cmd_usr(ch_cmd_usr), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready),
        .ch_rsp_rdata(ch_rsp_rdata), .ch_rsp_usr(ch_rsp_usr),
        .c_cmd_valid(c_cmd_valid), .c_cmd_ready(c_cmd_ready), .c_cmd_read(c_cmd_read),
        .c_cmd_addr(c_cmd_addr), .c_cmd_wdata(c_cmd_wdata), .c_cmd_wmask(c_cmd_wmask),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_rdata(c_rsp_rdata),
        .sram_ctrl_active(sram_ctrl_active), .proto_err(proto_err),
        .dbg_arb_state(dbg_arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus state, one entry per channel
    logic [CH-1:0]    v_a;
    logic [CH-1:0]    rd_a;
    logic [AW-1:0]    addr_a [CH];
    logic [DW-1:0]    wd_a   [CH];
    logic [MW-1:0]    wm_a   [CH];
    logic [USR_W-1:0] usr_a  [CH];
    logic [CH-1:0]    rrdy;
    logic             crdy;
    logic             crv;
    logic [DW-1:0]    crd;
    logic             cgstop;

    // reference model: outstanding requests in issue order, {cid, usr}
    logic [TAG_W-1:0] exp_q[$];
    int               rr_m;
    bit               lock_v;
    int               lock_ch;
    bit               proto_m;
    bit               last_accept;
    int               last_grant;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rr_m    = 0;
        lock_v  = 0;
        lock_ch = 0;
        proto_m = 0;
    endtask

    task automatic idle();
        v_a    = '0;
        rd_a   = '0;
        rrdy   = '0;
        crdy   = 1'b0;
        crv    = 1'b0;
        crd    = '0;
        cgstop = 1'b0;
        for (int i = 0; i < CH; i++) begin
            addr_a[i] = '0;
            wd_a[i]   = '0;
            wm_a[i]   = '0;
            usr_a[i]  = '0;
        end
    endtask

    // driver: apply the stimulus state to the DUT pins and let combinational paths settle
    task automatic settle();
        for (int i = 0; i < CH; i++) begin
            ch_cmd_valid[i]              = v_a[i];
            ch_cmd_read[i]               = rd_a[i];
            ch_cmd_addr[i*AW +: AW]      = addr_a[i];
            ch_cmd_wdata[i*DW +: DW]     = wd_a[i];
            ch_cmd_wmask[i*MW +: MW]     = wm_a[i];
            ch_cmd_usr[i*USR_W +: USR_W] = usr_a[i];
        end
        ch_rsp_ready = rrdy;
        c_cmd_ready  = crdy;
        c_rsp_valid  = crv;
        c_rsp_rdata  = crd;
        tcm_cgstop   = cgstop;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int model_grant();
        if (lock_v && v_a[lock_ch]) return lock_ch;
        for (int i = 0; i < CH; i++) begin
            if (v_a[(rr_m + i) % CH]) return (rr_m + i) % CH;
        end
        return rr_m;
    endfunction

    // scoreboard step: compare all outputs for this cycle, then advance the model
    // across the coming clock edge
    task automatic step();
        int               g;
        int               hcid;
        bit               any_v;
        bit               full_m;
        bit               empty_m;
        bit               cv;
        bit               crr;
        logic [CH-1:0]    exp_rv;
        logic [CH-1:0]    exp_rdy;
        logic [TAG_W-1:0] head;
        logic [TAG_W-1:0] popped;

        full_m  = (exp_q.size() == OST);
        empty_m = (exp_q.size() == 0);
        any_v   = (v_a != '0);
        g       = model_grant();
        cv      = any_v && !full_m;

        chk("c_cmd_valid", c_cmd_valid, cv);
        chk("arb_hold", dbg_arb_state == ARB_HOLD, lock_v);
        if (any_v) begin
            exp_rdy = '0;
            if (crdy && !full_m) exp_rdy[g] = 1'b1;
            chk("ch_cmd_ready", ch_cmd_ready, exp_rdy);
            chk("c_cmd_addr", c_cmd_addr, addr_a[g] >> AW_LSB);
            chk("c_cmd_wdata", c_cmd_wdata, wd_a[g]);
            chk("c_cmd_wmask", c_cmd_wmask, wm_a[g]);
            chk("c_cmd_read", c_cmd_read, rd_a[g]);
        end

        exp_rv = '0;
        crr    = 1'b0;
        if (!empty_m) begin
            head = exp_q[0];
            hcid = int'(head[TAG_W-1 -: CID_W]);
            if (crv) exp_rv[hcid] = 1'b1;
            crr = rrdy[hcid];
            chk("ch_rsp_usr", ch_rsp_usr, head[USR_W-1:0]);
        end
        chk("ch_rsp_valid", ch_rsp_valid, exp_rv);
        chk("c_rsp_ready", c_rsp_ready, crr);
        chk("ch_rsp_rdata", ch_rsp_rdata, crd);
        chk("active", sram_ctrl_active, cgstop || any_v || !empty_m || crv);
        chk("proto_err", proto_err, proto_m);

        last_accept = cv && crdy;
        last_grant  = g;
        if (crv && crr) popped = exp_q.pop_front();
        if (last_accept) exp_q.push_back({CID_W'(g), usr_a[g]});
        lock_v  = cv && !crdy;
        lock_ch = g;
        if (last_accept) rr_m = (g + 1) % CH;
        if (crv && empty_m) proto_m = 1;

        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        model_reset();
        do_reset();

        // reset state
        settle();
        chk("rst_c_cmd_valid", c_cmd_valid, 0);
        chk("rst_rsp_valid", ch_rsp_valid, 0);
        chk("rst_proto", proto_err, 0);
        step();

        // two channels always valid: grants alternate, address drops the byte offset
        v_a = 2'b11; rd_a = 2'b11; crdy = 1'b1;
        addr_a[0] = 32'h100; addr_a[1] = 32'h204;
        usr_a[0]  = 3'd5;    usr_a[1]  = 3'd6;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("alt_grant", ch_cmd_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 0) chk("addr_shift", c_cmd_addr, 30'h40);
            step();
        end
        // four outstanding: full blocks, and a pop alone reopens ready one cycle later
        settle();
        chk("full_block", ch_cmd_ready, 2'b00);
        step();
        crv = 1'b1; rrdy = 2'b11; crd = 32'hdead_beef;
        settle();
        chk("full_pop_cycle", ch_cmd_ready, 2'b00);
        step();
        crv = 1'b0;
        settle();
        chk("reopen", ch_cmd_ready, 2'b01);
        step();
        v_a = 2'b00; crv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            crd = $urandom;
            settle();
            step();
        end
        crv = 1'b0;

        // bring rr_ptr back to 0, then hold ch1 while ch0 joins
        v_a = 2'b10; settle(); step();
        v_a = 2'b00; crv = 1'b1; settle(); step();
        crv = 1'b0; crdy = 1'b0;
        v_a = 2'b10; settle(); step();
        v_a = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("lock_hold", c_cmd_addr, 30'h81);
            step();
        end
        crdy = 1'b1;
        settle();
        chk("lock_accept", ch_cmd_ready, 2'b10);
        step();
        settle();
        chk("after_lock", c_cmd_addr, 30'h40);
        step();
        v_a = 2'b00; crv = 1'b1;
        for (int k = 0; k < 2; k++) begin settle(); step(); end
        crv = 1'b0;

        // four reads usr 5,6,7,1 then fifth blocked; ch0 rsp stall blocks ch1
        v_a = 2'b01; usr_a[0] = 3'd5; settle(); step();
        v_a = 2'b10; usr_a[1] = 3'd6; settle(); step();
        v_a = 2'b01; usr_a[0] = 3'd7; settle(); step();
        v_a = 2'b10; usr_a[1] = 3'd1; settle(); step();
        v_a = 2'b01;
        settle();
        chk("fifth_blocked", ch_cmd_ready, 2'b00);
        step();
        v_a = 2'b00; crv = 1'b1; rrdy = 2'b10;
        for (int k = 0; k < 2; k++) begin
            crd = $urandom;
            settle();
            chk("stall_valid", ch_rsp_valid, 2'b01);
            chk("stall_cready", c_rsp_ready, 0);
            step();
        end
        rrdy = 2'b11;
        settle();
        chk("rel_ch0_valid", ch_rsp_valid, 2'b01);
        chk("rel_ch0_usr", ch_rsp_usr, 3'd5);
        step();
        settle();
        chk("rel_ch1_valid", ch_rsp_valid, 2'b10);
        chk("rel_ch1_usr", ch_rsp_usr, 3'd6);
        step();
        for (int k = 0; k < 2; k++) begin settle(); step(); end
        crv = 1'b0;

        // randomized traffic, each channel holding its request until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++) begin
                if (!v_a[i] && $urandom_range(0, 2) != 0) begin
                    v_a[i]    = 1'b1;
                    rd_a[i]   = 1'($urandom_range(0, 1));
                    addr_a[i] = $urandom;
                    wd_a[i]   = $urandom;
                    wm_a[i]   = 4'($urandom_range(0, 15));
                    usr_a[i]  = 3'($urandom_range(0, 7));
                end
            end
            crdy   = ($urandom_range(0, 3) != 0);
            rrdy   = 2'($urandom_range(0, 3));
            crv    = (exp_q.size() != 0) && ($urandom_range(0, 1) == 1);
            crd    = $urandom;
            cgstop = ($urandom_range(0, 7) == 0);
            settle();
            step();
            if (last_accept) v_a[last_grant] = 1'b0;
        end
        v_a = 2'b00; cgstop = 1'b0; crv = 1'b1; rrdy = 2'b11; crdy = 1'b0;
        for (int k = 0; k < 2 * OST && exp_q.size() != 0; k++) begin
            crd = $urandom;
            settle();
            step();
        end
        chk("drain_done", exp_q.size(), 0);
        crv = 1'b0;

        // response with nothing outstanding: sticky protocol error, nothing routed
        idle();
        crv = 1'b1; rrdy = 2'b11;
        settle();
        chk("proto_pre", proto_err, 0);
        chk("proto_rsp_valid", ch_rsp_valid, 2'b00);
        chk("proto_cready", c_rsp_ready, 0);
        step();
        crv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("proto_sticky", proto_err, 1);
            step();
        end

        // reset with three outstanding clears FIFO, rr_ptr and proto_err
        v_a = 2'b01; crdy = 1'b1; addr_a[0] = 32'h100; addr_a[1] = 32'h204;
        for (int k = 0; k < 3; k++) begin settle(); step(); end
        idle();
        do_reset();
        v_a = 2'b11; crv = 1'b1; rrdy = 2'b11; crdy = 1'b0;
        addr_a[0] = 32'h100; addr_a[1] = 32'h204;
        settle();
        chk("rst2_proto", proto_err, 0);
        chk("rst2_rsp_valid", ch_rsp_valid, 2'b00);
        chk("rst2_grant", c_cmd_addr, 30'h40);
        chk("rst2_cvalid", c_cmd_valid, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
